// File: rtl/weight_update_unit_if.sv
// Port bundle for weight_update_unit: commit strobe, weight load, gradient stream and status.
// update_count exists only when UPDATE_COUNT_EN is defined.
interface weight_update_unit_if #(
    parameter int WIDTH = 16
);
    logic                    enable_update;
    logic                    load_weight;
    logic signed [WIDTH-1:0] load_value;
    logic                    delta_valid;
    logic signed [WIDTH-1:0] delta_in;
    logic signed [WIDTH-1:0] weight_out;
    logic                    update_done;
    logic                    acc_overflow;
`ifdef UPDATE_COUNT_EN
    logic [15:0]             update_count;
`endif

    modport master (
        output enable_update,
        output load_weight,
        output load_value,
        output delta_valid,
        output delta_in,
        input  weight_out,
        input  update_done,
`ifdef UPDATE_COUNT_EN
        input  update_count,
`endif
        input  acc_overflow
    );

    modport slave (
        input  enable_update,
        input  load_weight,
        input  load_value,
        input  delta_valid,
        input  delta_in,
        output weight_out,
        output update_done,
`ifdef UPDATE_COUNT_EN
        output update_count,
`endif
        output acc_overflow
    );
endinterface

// File: rtl/weight_update_unit.sv
// Single-coefficient weight register with saturating gradient accumulator and a
// three-state commit pipeline (w -= acc >>> LR_SHIFT). Define UPDATE_COUNT_EN for update_count.
module weight_update_unit #(
    parameter int                      WIDTH       = 16,
    parameter int                      ACC_WIDTH   = 24,
    parameter int                      LR_SHIFT    = 3,
    parameter logic signed [WIDTH-1:0] INIT_WEIGHT = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    weight_update_unit_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCALE = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]                  state_reg, state_next;
    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic signed [ACC_WIDTH-1:0] commit_reg, commit_next;
    logic signed [ACC_WIDTH:0]   diff_reg, diff_next;
    logic signed [WIDTH-1:0]     weight_reg, weight_next;
    logic                        done_reg, done_next;
    logic                        ovf_reg, ovf_next;

    logic [ACC_WIDTH-1:0]        delta_ext;
    logic [ACC_WIDTH:0]          acc_sum;
    logic                        acc_clamp;
    logic [ACC_WIDTH-1:0]        acc_sat;
    logic signed [ACC_WIDTH-1:0] commit_shift;
    logic [ACC_WIDTH:0]          diff_calc;
    logic [ACC_WIDTH-WIDTH+1:0]  diff_hi;
    logic [WIDTH-1:0]            weight_sat;

`ifdef UPDATE_COUNT_EN
    logic [15:0]                 count_reg, count_next;
`endif

    // Datapath helpers: the accumulator sum carries one guard bit so a clamp is
    // detectable as disagreement between the two top bits.
    always_comb begin
        delta_ext    = {{(ACC_WIDTH-WIDTH){bus.delta_in[WIDTH-1]}}, bus.delta_in};
        acc_sum      = {acc_reg[ACC_WIDTH-1], acc_reg} + {delta_ext[ACC_WIDTH-1], delta_ext};
        acc_clamp    = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
        acc_sat      = acc_clamp ? (acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                 : acc_sum[ACC_WIDTH-1:0];
        commit_shift = commit_reg >>> LR_SHIFT;
        diff_calc    = {{(ACC_WIDTH+1-WIDTH){weight_reg[WIDTH-1]}}, weight_reg}
                     - {commit_shift[ACC_WIDTH-1], commit_shift};
        diff_hi      = diff_reg[ACC_WIDTH:WIDTH-1];
        if ((&diff_hi) || !(|diff_hi)) begin
            weight_sat = diff_reg[WIDTH-1:0];
        end else begin
            weight_sat = diff_reg[ACC_WIDTH] ? W_MIN : W_MAX;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        commit_next = commit_reg;
        diff_next   = diff_reg;
        weight_next = weight_reg;
        done_next   = 1'b0;
        ovf_next    = ovf_reg;

        if (bus.load_weight) begin
            weight_next = bus.load_value;
            acc_next    = '0;
            ovf_next    = 1'b0;
            state_next  = IDLE;
        end else begin
            // A delta arriving with the commit strobe opens the next window.
            if (state_reg == IDLE && bus.enable_update) begin
                commit_next = acc_reg;
                acc_next    = bus.delta_valid ? delta_ext : '0;
                state_next  = SCALE;
            end else if (bus.delta_valid) begin
                acc_next = acc_sat;
                if (acc_clamp) begin
                    ovf_next = 1'b1;
                end
            end

            case (state_reg)
                IDLE: ;
                SCALE: begin
                    diff_next  = diff_calc;
                    state_next = WRITE;
                end
                WRITE: begin
                    weight_next = weight_sat;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef UPDATE_COUNT_EN
    always_comb begin
        count_next = count_reg;
        if (bus.load_weight) begin
            count_next = '0;
        end else if (done_next) begin
            count_next = count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bus.update_count = count_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            commit_reg <= '0;
            diff_reg   <= '0;
            weight_reg <= INIT_WEIGHT;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            commit_reg <= commit_next;
            diff_reg   <= diff_next;
            weight_reg <= weight_next;
            done_reg   <= done_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign bus.weight_out   = weight_reg;
    assign bus.update_done  = done_reg;
    assign bus.acc_overflow = ovf_reg;
endmodule

// File: tb/tb_weight_update_unit.sv
// Directed bench for weight_update_unit: cycle-vector table plus hand sequences for
// accumulator saturation and commits interrupted by reset or load_weight.
module tb_weight_update_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    weight_update_unit_if #(.WIDTH(16)) bus ();

    weight_update_unit #(
        .WIDTH      (16),
        .ACC_WIDTH  (24),
        .LR_SHIFT   (3),
        .INIT_WEIGHT(16'sh0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        dv;
        logic [15:0] d;
        logic [15:0] ew;
        logic        ed;
        logic        eo;
    } vec_t;

    vec_t vecs [64];
    int   nv     = 0;
    int   total  = 0;
    int   passed = 0;

    task automatic add(input logic ld, input logic [15:0] lv, input logic en,
                       input logic dv, input logic [15:0] d,
                       input logic [15:0] ew, input logic ed, input logic eo);
        vecs[nv] = '{ld: ld, lv: lv, en: en, dv: dv, d: d, ew: ew, ed: ed, eo: eo};
        nv++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] lv, input logic en,
                        input logic dv, input logic [15:0] d);
        @(negedge clk);
        bus.load_weight   = ld;
        bus.load_value    = lv;
        bus.enable_update = en;
        bus.delta_valid   = dv;
        bus.delta_in      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
`ifdef UPDATE_COUNT_EN
        logic [15:0] cnt;
`endif
        reset             = 1'b1;
        bus.load_weight   = 1'b0;
        bus.load_value    = '0;
        bus.enable_update = 1'b0;
        bus.delta_valid   = 1'b0;
        bus.delta_in      = '0;

        // ld, lv, en, dv, d, expected weight, expected done, expected overflow
        add(1, 16'h0400, 0, 0, 16'h0000, 16'h0400, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 16'h0, 0, 1, 16'h0080, 16'h0400, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0400, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0400, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0380, 1, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0380, 0, 0);
        // Negative clamp: 0x8010 - 0x0200 underflows
        add(1, 16'h8010, 0, 0, 16'h0000, 16'h8010, 0, 0);
        add(0, 16'h0000, 0, 1, 16'h0800, 16'h8010, 0, 0);
        add(0, 16'h0000, 0, 1, 16'h0800, 16'h8010, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h8010, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h8010, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h8000, 1, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h8000, 0, 0);
        // Same-cycle delta goes to the next window; strobes in SCALE/WRITE ignored
        add(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 16'h0000, 0, 1, 16'h0100, 16'h0000, 0, 0);
        add(0, 16'h0000, 1, 1, 16'h0010, 16'h0000, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'hFFE0, 1, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'hFFE0, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'hFFE0, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'hFFDE, 1, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'hFFDE, 0, 0);
        // load_weight beats enable_update and delta_valid
        add(1, 16'h1234, 1, 1, 16'h0100, 16'h1234, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 1, 0);
        // Positive clamp: 0x7FF0 + 0x0020 overflows
        add(1, 16'h7FF0, 0, 0, 16'h0000, 16'h7FF0, 0, 0);
        add(0, 16'h0000, 0, 1, 16'hFF00, 16'h7FF0, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h7FF0, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h7FF0, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 1, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_weight", bus.weight_out, 16'h0000);
        chk("reset_done", 16'(bus.update_done), 16'h0000);
        chk("reset_ovf", 16'(bus.acc_overflow), 16'h0000);
        @(negedge clk);
        reset = 1'b0;

`ifdef UPDATE_COUNT_EN
        cnt = 16'h0000;
`endif
        for (int i = 0; i < nv; i++) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].dv, vecs[i].d);
            $display("vec %0d: ld=%b en=%b dv=%b d=%h -> w=%h done=%b ovf=%b", i,
                     vecs[i].ld, vecs[i].en, vecs[i].dv, vecs[i].d,
                     bus.weight_out, bus.update_done, bus.acc_overflow);
            chk($sformatf("vec%0d_weight", i), bus.weight_out, vecs[i].ew);
            chk($sformatf("vec%0d_done", i), 16'(bus.update_done), 16'(vecs[i].ed));
            chk($sformatf("vec%0d_ovf", i), 16'(bus.acc_overflow), 16'(vecs[i].eo));
`ifdef UPDATE_COUNT_EN
            if (vecs[i].ld) cnt = 16'h0000;
            else if (vecs[i].ed) cnt = cnt + 16'd1;
            chk($sformatf("vec%0d_count", i), bus.update_count, cnt);
`endif
        end

        // Accumulator saturation: 256 x 0x7FFF fits, the 257th clamps to 0x7FFFFF
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7FFF);
            if (i == 256) chk("ovf_before_clamp", 16'(bus.acc_overflow), 16'h0000);
            if (i == 257) chk("ovf_at_clamp", 16'(bus.acc_overflow), 16'h0001);
        end
        $display("sat: 300 deltas of 7fff -> ovf=%b", bus.acc_overflow);
        chk("ovf_after_300", 16'(bus.acc_overflow), 16'h0001);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        idle();
        idle();
        $display("sat commit: w=%h done=%b ovf=%b", bus.weight_out, bus.update_done, bus.acc_overflow);
        chk("sat_commit_weight", bus.weight_out, 16'h8000);
        chk("sat_commit_done", 16'(bus.update_done), 16'h0001);
        chk("ovf_sticky_after_commit", 16'(bus.acc_overflow), 16'h0001);
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("ovf_cleared_by_load", 16'(bus.acc_overflow), 16'h0000);

        // Reset one cycle after the commit strobe kills the pending write
        step(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        reset             = 1'b1;
        bus.enable_update = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_int_w1", bus.weight_out, 16'h0000);
        chk("rst_int_d1", 16'(bus.update_done), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_int_w2", bus.weight_out, 16'h0000);
        chk("rst_int_d2", 16'(bus.update_done), 16'h0000);
        idle();
        $display("reset interrupt: w=%h done=%b", bus.weight_out, bus.update_done);
        chk("rst_int_w3", bus.weight_out, 16'h0000);
        chk("rst_int_d3", 16'(bus.update_done), 16'h0000);

        // load_weight one cycle after the commit strobe discards the commit
        step(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 16'h0555, 1'b0, 1'b0, 16'h0000);
        chk("ld_int_w1", bus.weight_out, 16'h0555);
        chk("ld_int_d1", 16'(bus.update_done), 16'h0000);
        for (int i = 2; i <= 3; i++) begin
            idle();
            chk($sformatf("ld_int_w%0d", i), bus.weight_out, 16'h0555);
            chk($sformatf("ld_int_d%0d", i), 16'(bus.update_done), 16'h0000);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        idle();
        idle();
        $display("load interrupt: w=%h done=%b", bus.weight_out, bus.update_done);
        chk("ld_int_empty_commit_w", bus.weight_out, 16'h0555);
        chk("ld_int_empty_commit_d", 16'(bus.update_done), 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
